// File: rtl/adder_dft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_dft_pkg
// Description : Shared types and constants for the ripple-adder DFT stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_dft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [7:0] c_LFSR_TAPS_DEFAULT = 8'hB8;
  localparam logic [7:0] c_SEED_DEFAULT      = 8'h01;

endpackage : adder_dft_pkg
`default_nettype wire

// File: rtl/galois_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : galois_lfsr
// Description : Right-shift Galois LFSR with synchronous load and step enables.
// Revision    : 1.0 - initial release
// ============================================================================
module galois_lfsr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_lfsr;

  assign o_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  // Load takes priority so a new run always starts from its seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= RESET_VAL;
    end else if (i_load) begin
      r_lfsr <= i_load_val;
    end else if (i_step) begin
      r_lfsr <= o_next;
    end
  end

endmodule : galois_lfsr
`default_nettype wire

// File: rtl/adder_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : adder_stim_gen
// Description : Valid/ready 2-bit stimulus source (exhaustive or LFSR) for the
//               ripple-adder DFT chain.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_stim_gen
  import adder_dft_pkg::*;
#(
  parameter int                LFSR_W       = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = c_LFSR_TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = c_SEED_DEFAULT,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [CNT_W-1:0]  i_num_patterns,
  output logic              o_pin_a,
  output logic              o_pin_b,
  output logic              o_pat_valid,
  input  logic              i_pat_ready,
  output logic [CNT_W-1:0]  o_pat_index,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;
  logic              r_mode;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_index;
  logic [1:0]        r_cnt;
  logic              r_pin_a;
  logic              r_pin_b;
  logic              r_valid;
  logic              w_xfer;
  logic              w_last;
  logic              w_lfsr_load;
  logic              w_lfsr_step;
  logic [LFSR_W-1:0] w_seed_eff;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [1:0]        w_cnt_next;
  logic              w_unused_lfsr;

  assign w_seed_eff    = (i_seed == '0) ? SEED_DEFAULT : i_seed;
  assign w_xfer        = r_valid && i_pat_ready;
  assign w_last        = (r_index == (r_num - c_ONE));
  assign w_cnt_next    = r_cnt + 2'd1;
  assign w_unused_lfsr = ^w_lfsr_next[LFSR_W-1:2];

  galois_lfsr #(
    .WIDTH     (LFSR_W),
    .TAPS      (LFSR_TAPS),
    .RESET_VAL (SEED_DEFAULT)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lfsr_load),
    .i_load_val (w_seed_eff),
    .i_step     (w_lfsr_step),
    .o_next     (w_lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lfsr_load  = 1'b0;
    w_lfsr_step  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_lfsr_load  = 1'b1;
          w_state_next = (i_num_patterns == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_next = DONE;
          end else begin
            w_lfsr_step = 1'b1;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pattern registers are loaded with the value the generator will hold after
  // this edge, so the presented pins always match the generator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_EXH;
      r_num   <= '0;
      r_index <= '0;
      r_cnt   <= 2'd0;
      r_pin_a <= 1'b0;
      r_pin_b <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_num   <= i_num_patterns;
            r_index <= '0;
            r_cnt   <= 2'd0;
            r_valid <= (i_num_patterns != '0);
            if (i_mode == MODE_LFSR) begin
              r_pin_a <= w_seed_eff[0];
              r_pin_b <= w_seed_eff[1];
            end else begin
              r_pin_a <= 1'b0;
              r_pin_b <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
            end else begin
              r_index <= r_index + c_ONE;
              r_cnt   <= w_cnt_next;
              if (r_mode == MODE_LFSR) begin
                r_pin_a <= w_lfsr_next[0];
                r_pin_b <= w_lfsr_next[1];
              end else begin
                r_pin_a <= w_cnt_next[0];
                r_pin_b <= w_cnt_next[1];
              end
            end
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_pin_a     = r_pin_a;
  assign o_pin_b     = r_pin_b;
  assign o_pat_valid = r_valid;
  assign o_pat_index = r_index;
  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);

endmodule : adder_stim_gen
`default_nettype wire

// File: tb/tb_adder_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_stim_gen
// Description : Directed self-checking bench for adder_stim_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_stim_gen;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_mode;
  logic [7:0]  i_seed;
  logic [15:0] i_num_patterns;
  logic        o_pin_a;
  logic        o_pin_b;
  logic        o_pat_valid;
  logic        i_pat_ready;
  logic [15:0] o_pat_index;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;

  adder_stim_gen dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_mode         (i_mode),
    .i_seed         (i_seed),
    .i_num_patterns (i_num_patterns),
    .o_pin_a        (o_pin_a),
    .o_pin_b        (o_pin_b),
    .o_pat_valid    (o_pat_valid),
    .i_pat_ready    (i_pat_ready),
    .o_pat_index    (o_pat_index),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Events seen mid-cycle; a valid&&ready here is a transfer at the next edge.
  always @(negedge clk) begin
    if (!rst && o_pat_valid && i_pat_ready) xfer_cnt++;
    if (!rst && o_done) done_cnt++;
    if (!rst && o_pat_valid) valid_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_seed = 8'h00;
    i_num_patterns = 16'd0; i_pat_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({o_pin_b, o_pin_a, o_pat_valid, o_busy, o_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b, want 00000", {o_pin_b, o_pin_a, o_pat_valid, o_busy, o_done});
    end
    checks++;
    if (o_pat_index !== 16'd0) begin
      errors++;
      $display("FAIL reset_index: got %0d, want 0", o_pat_index);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [1:0] exp_pat [6];
    exp_pat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    i_mode = 1'b0; i_num_patterns = 16'd6; i_pat_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o_pat_valid !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL exh_ctrl[%0d]: got v/b/d %b%b%b, want 110", i, o_pat_valid, o_busy, o_done);
      end
      checks++;
      if ({o_pin_b, o_pin_a} !== exp_pat[i] || o_pat_index !== 16'(i)) begin
        errors++;
        $display("FAIL exh_pat[%0d]: got pins %b idx %0d, want pins %b idx %0d",
                 i, {o_pin_b, o_pin_a}, o_pat_index, exp_pat[i], i);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_pat_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL exh_done: got d/v/b %b%b%b, want 100", o_done, o_pat_valid, o_busy);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL exh_after: got d/b %b%b, want 00", o_done, o_busy);
    end
  endtask

  task automatic test_lfsr();
    logic exp_a [4];
    logic exp_b [4];
    exp_a = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b1};
    i_mode = 1'b1; i_seed = 8'h01; i_num_patterns = 16'd4; i_pat_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_pat_valid !== 1'b1 || o_pin_a !== exp_a[i] || o_pin_b !== exp_b[i]) begin
        errors++;
        $display("FAIL lfsr_pat[%0d]: got v=%b a=%b b=%b, want v=1 a=%b b=%b",
                 i, o_pat_valid, o_pin_a, o_pin_b, exp_a[i], exp_b[i]);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_pat_valid !== 1'b0) begin
      errors++;
      $display("FAIL lfsr_done: got d/v %b%b, want 10", o_done, o_pat_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    xfer_cnt = 0; done_cnt = 0;
    i_mode = 1'b0; i_num_patterns = 16'd3; i_pat_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_pat_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_pat_valid !== 1'b1 || {o_pin_b, o_pin_a} !== 2'b01 || o_pat_index !== 16'd1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got v=%b pins=%b idx=%0d, want v=1 pins=01 idx=1",
                 k, o_pat_valid, {o_pin_b, o_pin_a}, o_pat_index);
      end
      if (k < 3) tick();
    end
    i_pat_ready = 1'b1;
    tick();
    checks++;
    if ({o_pin_b, o_pin_a} !== 2'b10 || o_pat_index !== 16'd2) begin
      errors++;
      $display("FAIL bp_resume: got pins=%b idx=%0d, want pins=10 idx=2", {o_pin_b, o_pin_a}, o_pat_index);
    end
    tick(); tick(); tick();
    checks++;
    if (xfer_cnt !== 3 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_counts: got xfers=%0d dones=%0d, want xfers=3 dones=1", xfer_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_cases();
    i_mode = 1'b1; i_seed = 8'h00; i_num_patterns = 16'd2; i_pat_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_pat_valid !== 1'b1 || o_pin_a !== 1'b1 || o_pin_b !== 1'b0) begin
      errors++;
      $display("FAIL zseed_first: got v=%b a=%b b=%b, want v=1 a=1 b=0", o_pat_valid, o_pin_a, o_pin_b);
    end
    tick();
    checks++;
    if (o_pin_a !== 1'b0 || o_pin_b !== 1'b0 || o_pat_index !== 16'd1) begin
      errors++;
      $display("FAIL zseed_second: got a=%b b=%b idx=%0d, want a=0 b=0 idx=1", o_pin_a, o_pin_b, o_pat_index);
    end
    tick(); tick();
    valid_cnt = 0; done_cnt = 0;
    i_num_patterns = 16'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_pat_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zcount_done: got d/v/b %b%b%b, want 100", o_done, o_pat_valid, o_busy);
    end
    tick(); tick();
    checks++;
    if (valid_cnt !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL zcount_counts: got valids=%0d dones=%0d, want valids=0 dones=1", valid_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    i_mode = 1'b0; i_num_patterns = 16'd10; i_pat_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (o_pat_index !== 16'd3 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got idx=%0d busy=%b, want idx=3 busy=1", o_pat_index, o_busy);
    end
    done_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({o_pin_b, o_pin_a, o_pat_valid, o_busy, o_done} !== 5'b0 || o_pat_index !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got outs=%b idx=%0d, want outs=00000 idx=0",
               {o_pin_b, o_pin_a, o_pat_valid, o_busy, o_done}, o_pat_index);
    end
    tick(); tick();
    checks++;
    if (done_cnt !== 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: got dones=%0d busy=%b, want dones=0 busy=0", done_cnt, o_busy);
    end
  endtask

  task automatic test_ignored_start();
    logic [1:0] exp_pat [4];
    exp_pat = '{2'b00, 2'b01, 2'b10, 2'b11};
    i_mode = 1'b0; i_num_patterns = 16'd4; i_pat_ready = 1'b0; i_start = 1'b1;
    tick();
    i_mode = 1'b1; i_seed = 8'h55; i_num_patterns = 16'd1; i_pat_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_pat_valid !== 1'b1 || {o_pin_b, o_pin_a} !== exp_pat[i] || o_pat_index !== 16'(i)) begin
        errors++;
        $display("FAIL ign_pat[%0d]: got v=%b pins=%b idx=%0d, want v=1 pins=%b idx=%0d",
                 i, o_pat_valid, {o_pin_b, o_pin_a}, o_pat_index, exp_pat[i], i);
      end
      if (i == 1) i_start = 1'b0;
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_pat_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_done: got d/v %b%b, want 10", o_done, o_pat_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_lfsr();
    test_backpressure();
    test_zero_cases();
    test_reset_midrun();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adder_stim_gen
`default_nettype wire
